// File: rtl/counter_sched_pkg.sv
// Shared types and default widths for the counter scheduler.
package counter_sched_pkg;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned NREQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting index after 'last', wrapping.
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    always_comb begin
        int unsigned idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        // Scan last+1 .. last+NREQ so 'last' itself is considered last.
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last) + i) % NREQ;
            if (!valid && req[IW'(idx)]) begin
                winner = IW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Shares one up counter among NREQ requesters: grant, clear, run to len, pulse done.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned CW   = CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    input  logic [CW-1:0]      count,
    output logic [NREQ-1:0]    grant,
    output logic [NREQ-1:0]    done,
    output logic               cnt_reset,
    output logic               cnt_enable,
    output logic               busy
);

    localparam int unsigned IW = $clog2(NREQ);

    sched_state_t    state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [CW-1:0]   len_q,   len_d;

    logic [IW-1:0]   arb_winner;
    logic            arb_valid;
    logic [CW-1:0]   len_sel;
    logic            req_own;
    logic [NREQ-1:0] owner_oh;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req    (req),
        .last   (last_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Length slice of the arbitration winner.
    always_comb begin
        len_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_winner == IW'(i)) begin
                len_sel = len[i*CW +: CW];
            end
        end
    end

    assign req_own  = req[owner_q];
    assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NREQ - 1);
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            len_q   <= len_d;
        end
    end

    // Next state and output decode; cnt_enable is the only input-dependent output.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        len_d      = len_q;
        grant      = '0;
        done       = '0;
        cnt_reset  = 1'b0;
        cnt_enable = 1'b0;
        busy       = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_winner;
                    len_d   = len_sel;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                grant     = owner_oh;
                cnt_reset = 1'b1;
                state_d   = req_own ? RUN : IDLE;
            end
            RUN: begin
                grant = owner_oh;
                if (!req_own) begin
                    state_d = IDLE;
                end else if (count == len_q) begin
                    state_d = DONE;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            DONE: begin
                grant   = owner_oh;
                done    = owner_oh;
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural 4-bit shared counter.
module tb_counter_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  count;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        cnt_reset;
    logic        cnt_enable;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] len;
        logic [3:0]  e_grant;
        logic [3:0]  e_done;
        logic        e_rst;
        logic        e_en;
        logic        e_busy;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vec[14];

    counter_sched #(.NREQ(4), .CW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .len        (len),
        .count      (count),
        .grant      (grant),
        .done       (done),
        .cnt_reset  (cnt_reset),
        .cnt_enable (cnt_enable),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared counter: cleared by its own reset or by the scheduler.
    always_ff @(posedge clk) begin
        if (reset || cnt_reset) count <= 4'd0;
        else if (cnt_enable)    count <= count + 4'd1;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin
        logic [3:0] rr_req, drop_p, raise_p, prev_g;
        logic [3:0] glog[6];
        logic [3:0] g_exp[6];
        int         nlog;
        logic       found;
        int         en_cyc, done_at, done_n;

        vec[0]  = '{4'h1, 16'h0005, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0};
        vec[1]  = '{4'h1, 16'h0005, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 4'd0};
        vec[2]  = '{4'h1, 16'h0005, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 4'd0};
        vec[3]  = '{4'h1, 16'h0005, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 4'd1};
        vec[4]  = '{4'h1, 16'h0005, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 4'd2};
        vec[5]  = '{4'h1, 16'h0005, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 4'd3};
        vec[6]  = '{4'h1, 16'h0005, 4'h1, 4'h0, 1'b0, 1'b1, 1'b1, 4'd4};
        vec[7]  = '{4'h1, 16'h0005, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 4'd5};
        vec[8]  = '{4'h0, 16'h0005, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1, 4'd5};
        vec[9]  = '{4'h4, 16'h0005, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd5};
        vec[10] = '{4'h4, 16'h0005, 4'h4, 4'h0, 1'b1, 1'b0, 1'b1, 4'd5};
        vec[11] = '{4'h4, 16'h0005, 4'h4, 4'h0, 1'b0, 1'b0, 1'b1, 4'd0};
        vec[12] = '{4'h0, 16'h0005, 4'h4, 4'h4, 1'b0, 1'b0, 1'b1, 4'd0};
        vec[13] = '{4'h0, 16'h0005, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0};

        g_exp[0] = 4'h1; g_exp[1] = 4'h2; g_exp[2] = 4'h8;
        g_exp[3] = 4'h1; g_exp[4] = 4'h2; g_exp[5] = 4'h8;

        reset = 1'b1;
        req   = 4'h0;
        len   = 16'h0;
        cyc();
        cyc();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_done",  32'(done),  32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_creset", 32'(cnt_reset), 32'h0);
        chk("rst_cen",   32'(cnt_enable), 32'h0);
        reset = 1'b0;

        // Single run of length 5, then a zero-length grant to requester 2.
        for (int i = 0; i < 14; i++) begin
            cyc();
            chk($sformatf("v%0d_grant", i), 32'(grant),      32'(vec[i].e_grant));
            chk($sformatf("v%0d_done", i),  32'(done),       32'(vec[i].e_done));
            chk($sformatf("v%0d_crst", i),  32'(cnt_reset),  32'(vec[i].e_rst));
            chk($sformatf("v%0d_cen", i),   32'(cnt_enable), 32'(vec[i].e_en));
            chk($sformatf("v%0d_busy", i),  32'(busy),       32'(vec[i].e_busy));
            chk($sformatf("v%0d_count", i), 32'(count),      32'(vec[i].e_cnt));
            req = vec[i].req;
            len = vec[i].len;
        end

        // Abort in RUN at count 3 of 10, then abort in CLEAR.
        cyc();
        chk("ab_start_idle", 32'(busy), 32'h0);
        req = 4'b0010;
        len = 16'h00A5;
        cyc();
        chk("ab_grant", 32'(grant), 32'h2);
        chk("ab_crst", 32'(cnt_reset), 32'h1);
        cyc();
        chk("ab_cnt0", 32'(count), 32'h0);
        chk("ab_en0", 32'(cnt_enable), 32'h1);
        repeat (3) cyc();
        chk("ab_cnt3", 32'(count), 32'h3);
        chk("ab_en_before", 32'(cnt_enable), 32'h1);
        req = 4'b0000;
        #1;
        chk("ab_en_low", 32'(cnt_enable), 32'h0);
        cyc();
        chk("ab_idle_busy", 32'(busy), 32'h0);
        chk("ab_idle_grant", 32'(grant), 32'h0);
        chk("ab_no_done", 32'(done), 32'h0);
        chk("ab_cnt_hold", 32'(count), 32'h3);
        req = 4'b0110;
        cyc();
        chk("ab_next_grant", 32'(grant), 32'h2);
        req = 4'b0000;
        cyc();
        chk("clear_abort_idle", 32'(busy), 32'h0);

        // Reset pulsed while count is 7.
        req = 4'b0100;
        len = 16'h0A00;
        cyc();
        chk("rs_grant", 32'(grant), 32'h4);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (count == 4'd7) begin
                found = 1'b1;
                break;
            end
        end
        chk("rs_reach7", 32'(found), 32'h1);
        reset = 1'b1;
        cyc();
        chk("rs_grant0", 32'(grant), 32'h0);
        chk("rs_done0",  32'(done),  32'h0);
        chk("rs_busy0",  32'(busy),  32'h0);
        chk("rs_crst0",  32'(cnt_reset), 32'h0);
        chk("rs_cen0",   32'(cnt_enable), 32'h0);
        chk("rs_cnt0",   32'(count), 32'h0);
        reset = 1'b0;
        req   = 4'hF;
        cyc();
        chk("rs_first_winner", 32'(grant), 32'h1);
        req = 4'h0;
        cyc();
        chk("rs_idle", 32'(busy), 32'h0);

        // Round-robin with requesters 0,1,3 dropping req for one cycle after done.
        rr_req  = 4'b1011;
        drop_p  = 4'h0;
        raise_p = 4'h0;
        prev_g  = 4'h0;
        nlog    = 0;
        for (int i = 0; i < 6; i++) glog[i] = 4'h0;
        len = 16'h2222;
        req = rr_req;
        for (int k = 0; k < 150 && nlog < 6; k++) begin
            cyc();
            if (grant != 4'h0 && prev_g == 4'h0) begin
                glog[nlog] = grant;
                nlog++;
            end
            prev_g = grant;
            for (int i = 0; i < 4; i++) begin
                if (raise_p[i]) begin
                    rr_req[i]  = 1'b1;
                    raise_p[i] = 1'b0;
                end else if (drop_p[i]) begin
                    rr_req[i]  = 1'b0;
                    drop_p[i]  = 1'b0;
                    raise_p[i] = 1'b1;
                end
                if (done[i]) drop_p[i] = 1'b1;
            end
            req = (nlog == 6) ? 4'h0 : rr_req;
        end
        chk("rr_nlog", 32'(nlog), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_order%0d", i), 32'(glog[i]), 32'(g_exp[i]));
        end
        cyc();
        chk("rr_end_idle", 32'(busy), 32'h0);

        // Maximum length with len toggled mid-grant.
        req     = 4'b0001;
        len     = 16'h000F;
        en_cyc  = 0;
        done_at = -1;
        done_n  = 0;
        for (int k = 1; k <= 19; k++) begin
            cyc();
            if (cnt_enable) en_cyc++;
            if (done != 4'h0) begin
                done_n++;
                done_at = k;
            end
            if (k == 1) chk("mx_grant", 32'(grant), 32'h1);
            if (k == 6) len = 16'h0003;
            if (k == 10) len = 16'hFFF0;
            if (k == 17) begin
                chk("mx_cnt15", 32'(count), 32'd15);
                chk("mx_en_off", 32'(cnt_enable), 32'h0);
            end
            if (k == 18) begin
                chk("mx_done", 32'(done), 32'h1);
                chk("mx_no_wrap", 32'(count), 32'd15);
                req = 4'h0;
            end
            if (k == 19) begin
                chk("mx_idle", 32'(busy), 32'h0);
                chk("mx_cnt_hold", 32'(count), 32'd15);
            end
        end
        chk("mx_en_cycles", 32'(en_cyc), 32'd15);
        chk("mx_done_once", 32'(done_n), 32'd1);
        chk("mx_done_at", 32'(done_at), 32'd18);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
